// File: rtl/weight_buf_loader.sv
// Weight buffer loader: packs DMA beats into weight rows and writes
// them to consecutive weight buffer addresses.
module weight_buf_loader #(
    parameter int DATA_W    = 512,
    parameter int ROW_BEATS = 16,
    parameter int ADDR_W    = 13
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start_valid,
    input  logic [ADDR_W-1:0]           weight_start_addr,
    input  logic [ADDR_W-1:0]           row_count,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        wbuf_wr_en,
    output logic [ADDR_W-1:0]           wbuf_wr_addr,
    output logic [DATA_W*ROW_BEATS-1:0] wbuf_wr_data,
    output logic                        busy,
    output logic                        done
);
    localparam int ROW_W  = DATA_W * ROW_BEATS;
    localparam int BEAT_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [ADDR_W-1:0]   r_row_cnt;
    logic [ADDR_W-1:0]   r_rows;
    logic [ADDR_W-1:0]   r_next_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ROW_W-1:0]    r_pack;
    logic [ROW_W-1:0]    r_wr_data;
    logic                r_wr_en;
    logic                w_start;
    logic                w_accept;
    logic                w_row_end;
    logic                w_last;

    assign w_start   = (r_state == S_IDLE) && start_valid;
    assign w_accept  = (r_state == S_LOAD) && in_valid;
    assign w_row_end = w_accept && (r_beat == BEAT_W'(ROW_BEATS - 1));
    assign w_last    = w_row_end && (r_row_cnt == r_rows - ADDR_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_state_nxt = (row_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job bookkeeping: counters are re-armed on every accepted start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat      <= '0;
            r_row_cnt   <= '0;
            r_rows      <= '0;
            r_next_addr <= '0;
        end else if (w_start) begin
            r_beat      <= '0;
            r_row_cnt   <= '0;
            r_rows      <= row_count;
            r_next_addr <= weight_start_addr;
        end else if (w_accept) begin
            if (w_row_end) begin
                r_beat      <= '0;
                r_row_cnt   <= r_row_cnt + ADDR_W'(1);
                r_next_addr <= r_next_addr + ADDR_W'(1);
            end else begin
                r_beat <= r_beat + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pack <= '0;
        end else if (w_accept) begin
            r_pack[DATA_W*r_beat +: DATA_W] <= in_data;
        end
    end

    // Separate output register lets the next row start filling during the write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_row_end;
            if (w_row_end) begin
                r_wr_addr <= r_next_addr;
                r_wr_data <= {in_data, r_pack[ROW_W-DATA_W-1:0]};
            end
        end
    end

    assign in_ready     = (r_state == S_LOAD);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign wbuf_wr_en   = r_wr_en;
    assign wbuf_wr_addr = r_wr_addr;
    assign wbuf_wr_data = r_wr_data;
endmodule

// File: tb/tb_weight_buf_loader.sv
// Bench for weight_buf_loader: directed jobs with pinned cycle checks
// plus randomized jobs, all scored against a behavioural row model.
module tb_weight_buf_loader;
    localparam int DW = 512;
    localparam int RB = 16;
    localparam int AW = 13;
    localparam int RW = DW * RB;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_valid = 1'b0;
    logic [AW-1:0] weight_start_addr = '0;
    logic [AW-1:0] row_count = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          wbuf_wr_en;
    logic [AW-1:0] wbuf_wr_addr;
    logic [RW-1:0] wbuf_wr_data;
    logic          busy;
    logic          done;

    weight_buf_loader dut (
        .clk              (clk),
        .rstn             (rstn),
        .start_valid      (start_valid),
        .weight_start_addr(weight_start_addr),
        .row_count        (row_count),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .wbuf_wr_en       (wbuf_wr_en),
        .wbuf_wr_addr     (wbuf_wr_addr),
        .wbuf_wr_data     (wbuf_wr_data),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tid   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_row(input string nm, input logic [RW-1:0] got,
                           input logic [RW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            for (int i = 0; i < RB; i++) begin
                if (got[DW*i +: DW] !== exp[DW*i +: DW]) begin
                    $display("FAIL %s lane %0d got=%0h exp=%0h", nm, i,
                             got[DW*i +: DW], exp[DW*i +: DW]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [DW-1:0] rep(input int k);
        return {16{32'(k)}};
    endfunction

    // Behavioural model: rows are collected beat by beat, each full row
    // becomes one expected write one cycle later at base+row_index.
    int            t = 0;
    logic          m_busy = 1'b0;
    logic          m_load = 1'b0;
    logic          m_idle;
    int            m_done_at = -1;
    int            m_wr_at = -1;
    int            m_k = 0;
    int            m_rows_done = 0;
    int            m_R = 0;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_addr_h = '0;
    logic [RW-1:0] m_data_h = '0;
    logic [RW-1:0] m_acc = '0;

    always @(negedge clk) begin
        t++;
        if (!rstn) begin
            m_busy      = 1'b0;
            m_load      = 1'b0;
            m_done_at   = -1;
            m_wr_at     = -1;
            m_k         = 0;
            m_rows_done = 0;
            m_addr_h    = '0;
            m_data_h    = '0;
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_wr_en", wbuf_wr_en, 1'b0);
            chk("rst_wr_addr", wbuf_wr_addr, '0);
            chk_row("rst_wr_data", wbuf_wr_data, '0);
        end else begin
            chk("in_ready", in_ready, m_load);
            chk("busy", busy, m_busy);
            chk("done", done, t == m_done_at);
            chk("wr_en", wbuf_wr_en, t == m_wr_at);
            chk("wr_addr", wbuf_wr_addr, m_addr_h);
            chk_row("wr_data", wbuf_wr_data, m_data_h);
            m_idle = !m_busy;
            if (t == m_done_at) m_busy = 1'b0;
            if (m_load && in_valid) begin
                m_acc[DW*m_k +: DW] = in_data;
                m_k++;
                if (m_k == RB) begin
                    m_k      = 0;
                    m_data_h = m_acc;
                    m_addr_h = AW'(int'(m_base) + m_rows_done);
                    m_rows_done++;
                    m_wr_at = t + 1;
                    if (m_rows_done == m_R) begin
                        m_load    = 1'b0;
                        m_done_at = t + 2;
                    end
                end
            end
            if (start_valid && m_idle) begin
                m_base      = weight_start_addr;
                m_R         = int'(row_count);
                m_rows_done = 0;
                m_k         = 0;
                m_busy      = 1'b1;
                if (row_count == '0) m_done_at = t + 1;
                else m_load = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectations at fixed cycles relative to start
    task automatic pin(input int c);
        case (tid)
            1: begin
                if (c == 17) begin
                    chk("t1_wr_en", wbuf_wr_en, 1'b1);
                    chk("t1_addr", wbuf_wr_addr, 13'h010);
                    chk("t1_lane0", wbuf_wr_data[0 +: DW], rep(0));
                    chk("t1_lane9", wbuf_wr_data[9*DW +: DW], rep(9));
                    chk("t1_lane15", wbuf_wr_data[15*DW +: DW], rep(15));
                end
                if (c == 18) chk("t1_done", done, 1'b1);
                if (c == 19) chk("t1_busy_off", busy, 1'b0);
            end
            2: begin
                if (c == 17) chk("t2_addr0", wbuf_wr_addr, 13'h1FFF);
                if (c == 33) chk("t2_addr1", wbuf_wr_addr, 13'h0000);
                if (c == 49) chk("t2_addr2", wbuf_wr_addr, 13'h0001);
                if (c == 49) chk("t2_wr_en", wbuf_wr_en, 1'b1);
                if (c == 50) chk("t2_ready_off", in_ready, 1'b0);
                if (c == 50) chk("t2_done", done, 1'b1);
            end
            3: begin
                if (c == 32) chk("t3_wr32", wbuf_wr_en, 1'b1);
                if (c == 63) chk("t3_wr63", wbuf_wr_en, 1'b0);
                if (c == 64) chk("t3_wr64", wbuf_wr_en, 1'b1);
                if (c == 64) chk("t3_lane4", wbuf_wr_data[4*DW +: DW], rep(20));
            end
            4: begin
                if (c == 1) chk("t4_done", done, 1'b1);
                if (c == 1) chk("t4_ready", in_ready, 1'b0);
            end
            5: begin
                if (c == 17) chk("t5_addr", wbuf_wr_addr, 13'h020);
                if (c == 18) chk("t5_done", done, 1'b1);
            end
            6: begin
                if (c == 17) chk("t6_addr", wbuf_wr_addr, 13'h040);
                if (c == 17) chk("t6_wr_en", wbuf_wr_en, 1'b1);
            end
            default: ;
        endcase
    endtask

    task automatic run_job(input logic [AW-1:0] a, input logic [AW-1:0] r,
                           input int mode, input int dup_at,
                           input int rst_at, output int nacc);
        int c;
        int dn;
        bit dup_done;
        nacc              = 0;
        c                 = 0;
        dn                = -1;
        dup_done          = 1'b0;
        start_valid       = 1'b1;
        weight_start_addr = a;
        row_count         = r;
        in_valid          = 1'b0;
        in_data           = '0;
        while (1) begin
            @(negedge clk);
            pin(c);
            if (in_valid && in_ready) nacc++;
            if (done && dn < 0) dn = c;
            if (dn >= 0 && c == dn + 1) break;
            if (c > 32 * int'(r) + 40) begin
                total++;
                bad++;
                $display("FAIL timeout tid=%0d cycle=%0d", tid, c);
                break;
            end
            tick();
            c++;
            start_valid = 1'b0;
            if (rst_at >= 0 && nacc >= rst_at) begin
                in_valid = 1'b0;
                rstn     = 1'b0;
                @(negedge clk);
                chk("t6_rst_addr", wbuf_wr_addr, '0);
                chk("t6_rst_busy", busy, 1'b0);
                tick();
                tick();
                rstn = 1'b1;
                break;
            end
            if (dn >= 0) begin
                in_valid = 1'b0;
            end else begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (c % 2 == 1);
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                if (mode == 2 && $urandom_range(0, 7) == 0) begin
                    start_valid       = 1'b1;
                    weight_start_addr = AW'($urandom());
                    row_count         = AW'($urandom_range(0, 3));
                end
            end
            if (mode < 2) begin
                in_data = rep(nacc);
            end else begin
                for (int i = 0; i < DW / 32; i++) in_data[32*i +: 32] = $urandom();
            end
            if (dup_at >= 0 && !dup_done && nacc == dup_at) begin
                start_valid       = 1'b1;
                weight_start_addr = 13'h100;
                row_count         = 13'd5;
                dup_done          = 1'b1;
            end
        end
        tick();
        start_valid = 1'b0;
        in_valid    = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) tick();
        @(negedge clk);
        chk("init_addr", wbuf_wr_addr, '0);
        chk("init_busy", busy, 1'b0);
        tick();
        rstn = 1'b1;
        tick();
        tid = 1;
        run_job(13'h010, 13'd1, 0, -1, -1, n);
        chk("t1_beats", n, 16);
        tid = 2;
        run_job(13'h1FFF, 13'd3, 0, -1, -1, n);
        chk("t2_beats", n, 48);
        tid = 3;
        run_job(13'h200, 13'd2, 1, -1, -1, n);
        chk("t3_beats", n, 32);
        tid = 4;
        run_job(13'h055, 13'd0, 0, -1, -1, n);
        chk("t4_beats", n, 0);
        tid = 5;
        run_job(13'h020, 13'd1, 0, 5, -1, n);
        chk("t5_beats", n, 16);
        tid = 6;
        run_job(13'h040, 13'd2, 0, -1, 20, n);
        chk("t6_beats", n, 20);
        tick();
        tid = 1;
        run_job(13'h010, 13'd1, 0, -1, -1, n);
        tid = 0;
        for (int j = 0; j < 12; j++) begin
            run_job(AW'($urandom()), AW'($urandom_range(1, 3)), 2, -1, -1, n);
        end
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
